// File: rtl/tx_pkg.sv
// Shared definitions for the serial transmit path: bit-order encodings and
// the width of the queued-word counter.
package tx_pkg;

  localparam bit TX_MSB_FIRST = 1'b1;
  localparam bit TX_LSB_FIRST = 1'b0;

  // Enough bits to hold 0..depth inclusive.
  function automatic int tx_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tx_word_fifo.sv
// Synchronous word FIFO feeding the transmit shifter. No read bypass: a word
// written this cycle is visible on rdata from the next cycle on.
module tx_word_fifo
  import tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              wdata,
  output logic [WIDTH-1:0]              rdata,
  output logic [tx_cnt_w(DEPTH)-1:0]    count,
  output logic                          full,
  output logic                          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = tx_cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  // Storage array carries data only and is never cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/tx_serializer.sv
// Parallel-to-serial transmit buffer: queues words in a small FIFO and shifts
// them out one bit per enable strobe, back-to-back, in either bit order.
module tx_serializer
  import tx_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter int   DEPTH     = 4,
  parameter bit   MSB_FIRST = TX_MSB_FIRST,
  parameter logic IDLE_VAL  = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       en,
  output logic                       dout,
  output logic                       dout_valid,
  output logic                       frame_start,
  output logic                       frame_done,
  output logic                       busy,
  output logic [tx_cnt_w(DEPTH)-1:0] fifo_count
);

  localparam int BW = $clog2(WIDTH + 1);

  logic             fifo_push;
  logic             fifo_pop;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;

  logic [WIDTH-1:0] shift_p1;
  logic [BW-1:0]    bits_left_p1;
  logic             dout_p1;
  logic             vld_p1;
  logic             start_p1;
  logic             done_p1;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Consumed bit leaves from the head end; vacated positions fill with 0.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready && !flush;
  assign fifo_pop  = en && (bits_left_p1 == '0) && !fifo_empty;

  tx_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Stage 1: shifter, bit counter and registered serial outputs.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      shift_p1     <= '0;
      bits_left_p1 <= '0;
      dout_p1      <= IDLE_VAL;
      vld_p1       <= 1'b0;
      start_p1     <= 1'b0;
      done_p1      <= 1'b0;
    end else begin
      dout_p1  <= IDLE_VAL;
      vld_p1   <= 1'b0;
      start_p1 <= 1'b0;
      done_p1  <= 1'b0;
      if (en) begin
        if (bits_left_p1 != '0) begin
          dout_p1      <= head_bit(shift_p1);
          shift_p1     <= advance(shift_p1);
          vld_p1       <= 1'b1;
          bits_left_p1 <= bits_left_p1 - BW'(1);
          done_p1      <= (bits_left_p1 == BW'(1));
        end else if (!fifo_empty) begin
          dout_p1      <= head_bit(fifo_rdata);
          shift_p1     <= advance(fifo_rdata);
          vld_p1       <= 1'b1;
          start_p1     <= 1'b1;
          bits_left_p1 <= BW'(WIDTH - 1);
        end
      end
    end
  end

  assign dout        = dout_p1;
  assign dout_valid  = vld_p1;
  assign frame_start = start_p1;
  assign frame_done  = done_p1;
  assign busy        = (bits_left_p1 != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_tx_serializer.sv
// Directed bench for tx_serializer: one MSB-first and one LSB-first instance
// share the same stimulus; expectations are hand-derived per scenario.
module tb_tx_serializer;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       en;

  logic       m_in_ready, m_dout, m_dout_valid, m_frame_start, m_frame_done, m_busy;
  logic [2:0] m_fifo_count;
  logic       l_in_ready, l_dout, l_dout_valid, l_frame_start, l_frame_done, l_busy;
  logic [2:0] l_fifo_count;

  int n_chk;
  int n_pass;

  tx_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1), .IDLE_VAL(1'b0)) u_msb (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(m_in_ready), .en(en), .dout(m_dout), .dout_valid(m_dout_valid),
    .frame_start(m_frame_start), .frame_done(m_frame_done), .busy(m_busy),
    .fifo_count(m_fifo_count)
  );

  tx_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0), .IDLE_VAL(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(l_in_ready), .en(en), .dout(l_dout), .dout_valid(l_dout_valid),
    .frame_start(l_frame_start), .frame_done(l_frame_done), .busy(l_busy),
    .fifo_count(l_fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] w0, w1, wf;
    logic [7:0] words [4];
    n_chk    = 0;
    n_pass   = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    in_data  = 8'h55;
    in_valid = 1'b1;
    en       = 1'b1;

    // Reset held 3 cycles with en and in_valid high
    repeat (3) tick();
    chk("rst_dout", m_dout, 1'b0);
    chk("rst_vld", m_dout_valid, 1'b0);
    chk("rst_cnt", m_fifo_count, 3'd0);
    chk("rst_rdy", m_in_ready, 1'b1);
    chk("rst_busy", m_busy, 1'b0);
    chk("rst_l_busy", l_busy, 1'b0);
    chk("rst_l_rdy", l_in_ready, 1'b1);
    rst      = 1'b0;
    in_valid = 1'b0;
    en       = 1'b0;
    tick();
    chk("rst_noenq", m_fifo_count, 3'd0);
    chk("rst_l_noenq", l_fifo_count, 3'd0);

    // Single word A5, MSB first
    in_data  = 8'hA5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    en       = 1'b1;
    tick();
    w0 = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("a5_bit%0d", i), m_dout, w0[7-i]);
      chk($sformatf("a5_vld%0d", i), m_dout_valid, 1'b1);
      chk($sformatf("a5_start%0d", i), m_frame_start, (i == 0));
      chk($sformatf("a5_done%0d", i), m_frame_done, (i == 7));
      tick();
    end
    chk("a5_idle_vld", m_dout_valid, 1'b0);
    chk("a5_idle_busy", m_busy, 1'b0);

    // Back-to-back 01 then 80, LSB first
    en       = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h01;
    tick();
    in_data  = 8'h80;
    tick();
    in_valid = 1'b0;
    en       = 1'b1;
    tick();
    w0 = 8'h01;
    w1 = 8'h80;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("b2b_bit%0d", i), l_dout, (i < 8) ? w0[i] : w1[i-8]);
      chk($sformatf("b2b_vld%0d", i), l_dout_valid, 1'b1);
      chk($sformatf("b2b_start%0d", i), l_frame_start, (i == 0 || i == 8));
      chk($sformatf("b2b_done%0d", i), l_frame_done, (i == 7 || i == 15));
      tick();
    end
    chk("b2b_idle_vld", l_dout_valid, 1'b0);

    // Backpressure: five pushes with en low, only four accepted
    en       = 1'b0;
    in_valid = 1'b1;
    words[0] = 8'h11;
    words[1] = 8'h22;
    words[2] = 8'h33;
    words[3] = 8'h44;
    for (int k = 0; k < 5; k++) begin
      in_data = (k < 4) ? words[k] : 8'h55;
      chk($sformatf("full_rdy%0d", k), m_in_ready, (k < 4));
      tick();
      chk($sformatf("full_cnt%0d", k), m_fifo_count, (k < 4) ? 3'(k + 1) : 3'd4);
    end
    chk("full_rdy_low", m_in_ready, 1'b0);
    in_valid = 1'b0;
    en       = 1'b1;
    tick();
    chk("full_pop_cnt", m_fifo_count, 3'd3);
    chk("full_pop_rdy", m_in_ready, 1'b1);
    for (int i = 0; i < 32; i++) begin
      wf = words[i/8];
      chk($sformatf("full_bit%0d", i), m_dout, wf[7 - (i % 8)]);
      chk($sformatf("full_vld%0d", i), m_dout_valid, 1'b1);
      tick();
    end
    chk("full_end_vld", m_dout_valid, 1'b0);
    chk("full_end_busy", m_busy, 1'b0);
    chk("full_end_cnt", m_fifo_count, 3'd0);

    // en gaps: F0 with en toggling
    en       = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hF0;
    tick();
    in_valid = 1'b0;
    w0 = 8'hF0;
    for (int i = 0; i < 8; i++) begin
      en = 1'b1;
      tick();
      chk($sformatf("gap_bit%0d", i), m_dout, w0[7-i]);
      chk($sformatf("gap_vld%0d", i), m_dout_valid, 1'b1);
      en = 1'b0;
      tick();
      chk($sformatf("gap_idle%0d", i), m_dout, 1'b0);
      chk($sformatf("gap_ivld%0d", i), m_dout_valid, 1'b0);
    end
    chk("gap_busy", m_busy, 1'b0);

    // Flush mid-word, then a fresh word
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    in_data  = 8'h00;
    tick();
    in_valid = 1'b0;
    en       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("fl_bit%0d", i), m_dout, 1'b1);
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_vld", m_dout_valid, 1'b0);
    chk("fl_cnt", m_fifo_count, 3'd0);
    chk("fl_busy", m_busy, 1'b0);
    chk("fl_done", m_frame_done, 1'b0);
    tick();
    chk("fl_still_idle", m_dout_valid, 1'b0);
    en       = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h81;
    tick();
    in_valid = 1'b0;
    en       = 1'b1;
    tick();
    w0 = 8'h81;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("post_bit%0d", i), m_dout, w0[7-i]);
      chk($sformatf("post_start%0d", i), m_frame_start, (i == 0));
      chk($sformatf("post_done%0d", i), m_frame_done, (i == 7));
      tick();
    end
    chk("post_idle_vld", m_dout_valid, 1'b0);
    chk("post_l_busy", l_busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
